pulse_stretch: RTL and testbench



---
 rtl/pulse_stretch.sv | 109 ++++++++++
 tb/tb_pulse_stretch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretch.sv
// Stretches single-cycle event pulses into fixed-length LED flashes separated by a
// mandatory dark gap; events arriving mid-flash are queued in a saturating counter.
module pulse_stretch #(
  parameter int HOLD_CYCLES = 20,
  parameter int GAP_CYCLES  = 10,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pulse_in,
  input  logic              clr_ovf,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow
);

  localparam int CNT_W = 20;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Current FSM state, kept as a named signal so checkers can bind to it.
  state_t           state;
  logic             pulse_d;
  logic [CNT_W-1:0] cnt;

  logic evt;
  logic cnt_zero;
  logic enq;
  logic deq;

  always_comb begin
    evt      = pulse_in & ~pulse_d;
    cnt_zero = (cnt == '0);
    enq      = evt && ((state == HOLD) || ((state == GAP) && !cnt_zero));
    // Queue-driven restart with no fresh event consumes one queued entry; a
    // coinciding event either replaces the consumed entry or is served directly.
    deq      = (state == GAP) && cnt_zero && (pend_cnt != '0) && !evt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      pulse_d  <= 1'b0;
      cnt      <= '0;
      led_out  <= 1'b0;
      busy     <= 1'b0;
      pend_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      pulse_d <= pulse_in;

      // A drop on the same edge overrides the clear below.
      if (clr_ovf) overflow <= 1'b0;
      if (enq) begin
        if (pend_cnt == PEND_MAX) overflow <= 1'b1;
        else                      pend_cnt <= pend_cnt + 1'b1;
      end else if (deq) begin
        pend_cnt <= pend_cnt - 1'b1;
      end

      case (state)
        IDLE: begin
          if (evt) begin
            state   <= HOLD;
            led_out <= 1'b1;
            busy    <= 1'b1;
            cnt     <= HOLD_LOAD;
          end
        end
        HOLD: begin
          if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
          end else begin
            state   <= GAP;
            led_out <= 1'b0;
            cnt     <= GAP_LOAD;
          end
        end
        GAP: begin
          if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
          end else if ((pend_cnt != '0) || evt) begin
            state   <= HOLD;
            led_out <= 1'b1;
            cnt     <= HOLD_LOAD;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          led_out <= 1'b0;
          busy    <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch with HOLD_CYCLES=4, GAP_CYCLES=2, PEND_W=2:
// a vector table for whole scenarios plus hand sequences for edge and reset cases.
module tb_pulse_stretch;

  logic       clk;
  logic       rstn;
  logic       pulse_in;
  logic       clr_ovf;
  logic       led_out;
  logic       busy;
  logic [1:0] pend_cnt;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  pulse_stretch #(
    .HOLD_CYCLES(4),
    .GAP_CYCLES (2),
    .PEND_W     (2)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .pulse_in(pulse_in),
    .clr_ovf (clr_ovf),
    .led_out (led_out),
    .busy    (busy),
    .pend_cnt(pend_cnt),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       p;
    logic       c;
    logic       led;
    logic       bsy;
    logic [1:0] pend;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic p, input logic c, input logic led,
                              input logic bsy, input logic [1:0] pend, input logic ovf);
    vec_t v;
    v.p = p; v.c = c; v.led = led; v.bsy = bsy; v.pend = pend; v.ovf = ovf;
    tbl.push_back(v);
  endfunction

  function automatic void add_n(input int n, input logic p, input logic c, input logic led,
                                input logic bsy, input logic [1:0] pend, input logic ovf);
    for (int i = 0; i < n; i++) add(p, c, led, bsy, pend, ovf);
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s #%0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int idx, input logic led,
                           input logic bsy, input logic [1:0] pend, input logic ovf);
    check({name, "_led"},  idx, {7'd0, led_out},  {7'd0, led});
    check({name, "_busy"}, idx, {7'd0, busy},     {7'd0, bsy});
    check({name, "_pend"}, idx, {6'd0, pend_cnt}, {6'd0, pend});
    check({name, "_ovf"},  idx, {7'd0, overflow}, {7'd0, ovf});
  endtask

  // Inputs change 1 time unit after an edge; outputs are read 1 unit after the next.
  task automatic step(input logic p, input logic c);
    pulse_in = p;
    clr_ovf  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 60) begin
      step(1'b0, 1'b0);
      n++;
    end
    check({name, "_idle_timeout"}, n, {7'd0, busy}, 8'd0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    rstn     = 1'b0;
    pulse_in = 1'b0;
    clr_ovf  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 0, 1'b0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // single 1-cycle event
    add(1, 0, 1, 1, 0, 0);
    add_n(3, 0, 0, 1, 1, 0, 0);
    add_n(2, 0, 0, 0, 1, 0, 0);
    add_n(2, 0, 0, 0, 0, 0, 0);
    // held level: one flash only
    add_n(4, 1, 0, 1, 1, 0, 0);
    add_n(2, 1, 0, 0, 1, 0, 0);
    add_n(4, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    // burst of three events
    add(1, 0, 1, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0);
    add(1, 0, 1, 1, 1, 0);
    add(0, 0, 1, 1, 1, 0);
    add(1, 0, 0, 1, 2, 0);
    add(0, 0, 0, 1, 2, 0);
    add_n(4, 0, 0, 1, 1, 1, 0);
    add_n(2, 0, 0, 0, 1, 1, 0);
    add_n(4, 0, 0, 1, 1, 0, 0);
    add_n(2, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    // overflow with drop+clear on one edge, then plain clear
    add(1, 0, 1, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0);
    add(1, 0, 1, 1, 1, 0);
    add(0, 0, 1, 1, 1, 0);
    add(1, 0, 0, 1, 2, 0);
    add(0, 0, 0, 1, 2, 0);
    add(1, 0, 1, 1, 2, 0);
    add(0, 0, 1, 1, 2, 0);
    add(1, 0, 1, 1, 3, 0);
    add(0, 0, 1, 1, 3, 0);
    add(1, 1, 0, 1, 3, 1);
    add(0, 0, 0, 1, 3, 1);
    add(0, 0, 1, 1, 2, 1);
    add(0, 1, 1, 1, 2, 0);
    add_n(2, 0, 0, 1, 1, 2, 0);
    add_n(2, 0, 0, 0, 1, 2, 0);
    add_n(4, 0, 0, 1, 1, 1, 0);
    add_n(2, 0, 0, 0, 1, 1, 0);
    add_n(4, 0, 0, 1, 1, 0, 0);
    add_n(2, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].p, tbl[i].c);
      check_all("tbl", i, tbl[i].led, tbl[i].bsy, tbl[i].pend, tbl[i].ovf);
    end

    // event on the final GAP edge with nothing queued
    step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    check_all("gap_end0_pre", 0, 1'b0, 1'b1, 2'd0, 1'b0);
    step(1'b1, 1'b0);
    check_all("gap_end0", 0, 1'b1, 1'b1, 2'd0, 1'b0);
    wait_idle("gap_end0");

    // same with one event queued
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    check_all("gap_end1_pre", 0, 1'b0, 1'b1, 2'd1, 1'b0);
    step(1'b1, 1'b0);
    check_all("gap_end1", 0, 1'b1, 1'b1, 2'd1, 1'b0);
    repeat (6) step(1'b0, 1'b0);
    check_all("gap_end1_next", 0, 1'b1, 1'b1, 2'd0, 1'b0);
    wait_idle("gap_end1");

    // reset in HOLD with two events queued
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check_all("rst_pre", 0, 1'b1, 1'b1, 2'd2, 1'b0);
    #2 rstn = 1'b0;
    #1;
    check_all("rst_async", 0, 1'b0, 1'b0, 2'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      check("rst_quiet_led", i, {7'd0, led_out}, 8'd0);
      check("rst_quiet_busy", i, {7'd0, busy}, 8'd0);
    end
    step(1'b1, 1'b0);
    check_all("rst_new_evt", 0, 1'b1, 1'b1, 2'd0, 1'b0);
    wait_idle("rst_new_evt");

    // pulse_in already high at reset release is an event
    @(negedge clk);
    rstn     = 1'b0;
    pulse_in = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check_all("rst_high", 0, 1'b1, 1'b1, 2'd0, 1'b0);
    wait_idle("rst_high");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
